keypad_scan: RTL
================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: sysclk cycles per column/sample period (>=2).
REQ-002 Parameter DEB_CNT, default 4: consecutive matching samples needed to accept a press or a release (>=1).
REQ-003 sysclk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 row  input  4  keypad rows, active-low, externally pulled up, asynchronous to sysclk.
REQ-006 col  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  last accepted key, code = 4*row_index + col_index.
REQ-008 key_valid  output  1  one-cycle pulse per accepted press.
REQ-009 key_held  output  1  high while the accepted key is still down (HELD state).
REQ-010 entry  output  16  hex entry register, for the 16-bit value path to the 4-digit display.

Function
REQ-011 row SHALL pass through a 2-flop synchronizer; all samples use the synchronized value.
REQ-012 Divider counts 0..SCAN_DIV-1 and wraps; a sample SHALL be taken only in the cycle the divider equals SCAN_DIV-1.
REQ-013 States SHALL be SCAN, DEBOUNCE, HELD.
REQ-014 SCAN: after each sample with no row low, col SHALL rotate 1110->1101->1011->0111->1110.
REQ-015 SCAN: a sample with any row low SHALL latch candidate code, set match count=1, freeze col, enter DEBOUNCE.
REQ-016 Row index SHALL be the lowest-numbered low row bit; col index SHALL be the position of the low col bit.
REQ-017 DEBOUNCE: a sample with the same code SHALL increment the count; a sample that is released or differs SHALL clear the count, rotate col, and return to SCAN.
REQ-018 When the count reaches DEB_CNT (including DEB_CNT=1 on the first sample), in the next cycle: key_code=candidate, key_valid=1 for exactly one cycle, entry updated, state=HELD.
REQ-019 entry update SHALL be entry <= {entry[11:0], key_code}; the oldest nibble is discarded.
REQ-020 HELD: col stays frozen and key_held=1; DEB_CNT consecutive samples with no row low SHALL return to SCAN with col rotated; any press sample resets the release count.
REQ-021 No second key_valid SHALL occur until after a return to SCAN; auto-repeat is not supported.
REQ-022 Other keys pressed during HELD SHALL be ignored.

Reset
REQ-023 While rst=1 at a clock edge: col=1110, key_code=0, key_valid=0, key_held=0, entry=0, state=SCAN, divider/counts/synchronizer cleared.
REQ-024 Reset asserted in DEBOUNCE or HELD SHALL abort without a key_valid pulse; reset takes precedence over any simultaneous event.

Configuration
REQ-025 Macro KEYPAD_CLEAR_EN: when defined, acceptance of code 4'hF SHALL set entry to 16'h0000 instead of shifting (key_valid and key_code still update); when undefined, 4'hF SHALL shift in like any other code.

Verification (SCAN_DIV=4, DEB_CNT=2)
REQ-026 rst held 3 cycles -> col=1110, entry=0000, key_valid=0, key_held=0; with rows idle, col rotates every 4 cycles.
REQ-027 row=1101 held while col=1011 (key 6) -> exactly one key_valid pulse with key_code=6 after the second matching sample; entry=0006; key_held=1 until 2 idle samples after release.
REQ-028 Presses 1,2,3,4,5 (each held then released) -> entry=2345 after the fifth pulse; five pulses total.
REQ-029 Bounce: row low for 1 sample then high, repeated -> no key_valid, state returns to SCAN and col resumes rotating.
REQ-030 rst asserted between the first and second matching sample -> no key_valid; all outputs at reset values.
REQ-031 Key 4'hF accepted with entry=ABCD -> with KEYPAD_CLEAR_EN entry=0000; without it entry=BCDF.

Source files
------------

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_if
// Description : Signal bundle between the 4x4 keypad scanner and the outside
//               world (keypad matrix and the 4-digit display path).
//               master : keypad_scan side (drives columns and key results)
//               slave  : keypad / consumer side (drives rows)
// Signals     : row[3:0]      keypad rows, active-low, pulled up, async
//               col[3:0]      column drive, active-low, one bit low
//               key_code[3:0] last accepted key (4*row_index + col_index)
//               key_valid     one-cycle pulse per accepted press
//               key_held      accepted key still held down
//               entry[15:0]   hex entry register for the display
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scan_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] entry;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held,
        output entry
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  entry
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : 4x4 matrix keypad scanner with debounce, single-shot press
//               reporting and a 4-nibble hex entry shift register.
//               Columns are driven active-low one at a time; rows are
//               synchronised and sampled once per SCAN_DIV clock period.
//               A press is accepted after DEB_CNT matching samples and is
//               released after DEB_CNT consecutive idle samples.
// Parameters  : SCAN_DIV - sysclk cycles per column/sample period (>= 2)
//               DEB_CNT  - matching samples to accept press/release (>= 1)
// Ports       : sysclk   - sole clock, rising edge
//               rst      - synchronous active-high reset
//               kp       - keypad_scan_if.master (row in; col, key_code,
//                          key_valid, key_held, entry out)
// Options     : KEYPAD_CLEAR_EN - when defined, accepting key 4'hF clears
//               the entry register instead of shifting it in.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 4
) (
    input  wire logic     sysclk,
    input  wire logic     rst,
    keypad_scan_if.master kp
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEB_TGT  = c_CNT_W'(DEB_CNT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [3:0] c_COL_RST  = 4'b1110;
    localparam logic [3:0] c_ROW_IDLE = 4'b1111;

    localparam logic [1:0] c_ST_SCAN     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_HELD     = 2'd2;

    typedef enum logic [1:0] {
        ST_SCAN     = c_ST_SCAN,
        ST_DEBOUNCE = c_ST_DEBOUNCE,
        ST_HELD     = c_ST_HELD
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_DIV_W-1:0] r_div;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_col;
    logic [3:0]         w_col_nxt;
    logic [3:0]         r_cand;
    logic [3:0]         w_cand_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic [15:0]        r_entry;

    logic               w_tick;
    logic               w_press;
    logic               w_accept;
    logic [1:0]         w_row_idx;
    logic [1:0]         w_col_idx;
    logic [3:0]         w_code;
    logic [3:0]         w_col_rot;

    // ------------------------------------------------------------------------
    // Row synchroniser. The "cleared" value is the idle (pulled-up) level so
    // that leaving reset never looks like every row being pressed.
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_row_meta <= c_ROW_IDLE;
            r_row_sync <= c_ROW_IDLE;
        end else begin
            r_row_meta <= kp.row;
            r_row_sync <= r_row_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Sample-period divider: one sample tick when the count hits its last value
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign w_tick = (r_div == c_DIV_LAST);

    // ------------------------------------------------------------------------
    // Key code derivation from the synchronised rows and the driven column.
    // Lowest-numbered low row wins when several rows are low.
    // ------------------------------------------------------------------------
    assign w_press = ~&r_row_sync;

    always_comb begin
        w_row_idx = 2'd0;
        if (!r_row_sync[0]) begin
            w_row_idx = 2'd0;
        end else if (!r_row_sync[1]) begin
            w_row_idx = 2'd1;
        end else if (!r_row_sync[2]) begin
            w_row_idx = 2'd2;
        end else if (!r_row_sync[3]) begin
            w_row_idx = 2'd3;
        end
    end

    always_comb begin
        w_col_idx = 2'd0;
        case (r_col)
            4'b1110: w_col_idx = 2'd0;
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    assign w_code    = {w_row_idx, w_col_idx};
    assign w_col_rot = {r_col[2:0], r_col[3]};
    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    // ------------------------------------------------------------------------
    // Scan FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Scan FSM: next state, column, candidate and shared match/release count.
    // r_cnt counts matching samples in DEBOUNCE and idle samples in HELD.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;

        case (r_state)
            ST_SCAN: begin
                if (w_tick) begin
                    if (w_press) begin
                        w_cand_nxt = w_code;
                        // With DEB_CNT == 1 the first sample already qualifies.
                        if (c_CNT_ONE == c_DEB_TGT) begin
                            w_accept    = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_cnt_nxt   = c_CNT_ONE;
                            w_state_nxt = ST_DEBOUNCE;
                        end
                    end else begin
                        w_col_nxt = w_col_rot;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (w_tick) begin
                    if (w_press && (w_code == r_cand)) begin
                        if (w_cnt_inc == c_DEB_TGT) begin
                            w_accept    = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_col_nxt   = w_col_rot;
                        w_state_nxt = ST_SCAN;
                    end
                end
            end

            ST_HELD: begin
                // Column stays frozen, so only the held key's column is
                // observed; any low row restarts the release count.
                if (w_tick) begin
                    if (w_press) begin
                        w_cnt_nxt = '0;
                    end else if (w_cnt_inc == c_DEB_TGT) begin
                        w_cnt_nxt   = '0;
                        w_col_nxt   = w_col_rot;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_col       <= c_COL_RST;
            r_cand      <= 4'h0;
            r_cnt       <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_entry     <= 16'h0000;
        end else begin
            r_col       <= w_col_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= w_cand_nxt;
`ifdef KEYPAD_CLEAR_EN
                if (w_cand_nxt == 4'hF) begin
                    r_entry <= 16'h0000;
                end else begin
                    r_entry <= {r_entry[11:0], w_cand_nxt};
                end
`else
                r_entry <= {r_entry[11:0], w_cand_nxt};
`endif
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign kp.col       = r_col;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = (r_state == ST_HELD);
    assign kp.entry     = r_entry;

endmodule
`default_nettype wire
